// File: rtl/right_rotate_deser_pkg.sv
// Shared types and helpers for the right_rotate_deser receiver.
//   deser_state_t : frame-alignment FSM states (IDLE, SHIFT)
//   cnt_w()       : bit-counter width for a given word width
package right_rotate_deser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    // Counter width is never allowed to collapse to zero bits.
    function automatic int unsigned cnt_w(input int unsigned dw);
        return (dw < 2) ? 1 : $clog2(dw);
    endfunction

endpackage

// File: rtl/deser_shreg.sv
// DW-bit right-shift register for an LSB-first serial stream.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : shift sin in at the MSB end this cycle
//   clr        : discard current contents (combined with en, sin lands on a zeroed register)
//   sin        : serial data in
//   q          : current register contents
//   next_word  : {sin, q[DW-1:1]}, the value a completing shift would produce
module deser_shreg
    import right_rotate_deser_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          clr,
    input  logic          sin,
    output logic [DW-1:0] q,
    output logic [DW-1:0] next_word
);

    always_comb begin
        next_word = {sin, q[DW-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            // Resync: start a fresh word, optionally with sin as its first bit.
            q <= en ? {sin, {(DW-1){1'b0}}} : '0;
        end else if (en) begin
            q <= next_word;
        end
    end

endmodule

// File: rtl/right_rotate_deser.sv
// Serial-to-parallel receiver with frame alignment and a valid/ready output register.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : begin/resync a frame (bit counter cleared)
//   abort       : drop partial word, return to IDLE (wins over start)
//   en, sin     : bit-valid qualifier and serial data (LSB first)
//   data_out    : completed word, valid while out_valid
//   out_valid   : data_out holds an unconsumed word
//   out_ready   : consumer accepts data_out when out_valid & out_ready
//   overrun     : sticky, a completed word was dropped; cleared by start
//   busy        : FSM is in SHIFT
module right_rotate_deser
    import right_rotate_deser_pkg::*;
#(
    parameter int unsigned DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          en,
    input  logic          sin,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          overrun,
    output logic          busy
);

    localparam int unsigned CW = cnt_w(DW);
    localparam logic [CW-1:0] CntMax = CW'(DW - 1);

    deser_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          ovr_q, ovr_d;

    logic          take;
    logic          complete;
    logic [DW-1:0] sh_q;
    logic [DW-1:0] sh_next;

    // A bit is accepted in SHIFT, or in the very cycle start opens the frame.
    assign take     = en && !abort && (state_q == SHIFT || start);
    // A start always begins a new word at bit 0, so it can never complete one.
    assign complete = take && !start && (cnt_q == CntMax);

    deser_shreg #(
        .DW(DW)
    ) u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (take),
        .clr       (start || abort),
        .sin       (sin),
        .q         (sh_q),
        .next_word (sh_next)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (start) begin
            state_d = SHIFT;
            cnt_d   = take ? CW'(1) : '0;
        end else if (take) begin
            cnt_d = complete ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (start) begin
            ovr_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || out_ready) begin
                data_d  = sh_next;
                valid_d = 1'b1;
            end else begin
                // Set after the start clear so a coincident drop stays flagged.
                ovr_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q == SHIFT);

endmodule
